board_store: RTL
================

Name: board_store

Overview:
Owns the Connect-Four board state: a 2-bit cell register array, a combinational read port, and a drop FSM. The drop FSM accepts a column and player, scans the column bottom-up for the first empty cell, and writes the piece there. It then reports the landed coordinates and pulses a start strobe so the win-check logic can read the updated board. It is the writer and read-responder for the board read interface (row_read/col_read in, 2-bit cell data out).

Parameters:
NUM_ROWS, 6, board rows; row 0 is the bottom row; must be <= 8.
NUM_COLS, 7, board columns; must be <= 8.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
drop_valid  input  1  drop request
drop_col  input  3  target column
player  input  2  piece to drop: 01 = P1, 10 = P2
drop_ready  output  1  FSM in IDLE and clear_board low
drop_done  output  1  one-cycle pulse: drop finished or rejected
drop_ok  output  1  valid while drop_done is high: 1 = piece placed
move_row  output  3  row where the last piece landed
move_col  output  3  column where the last piece landed
check_start  output  1  one-cycle pulse, coincident with drop_done when drop_ok=1
clear_board  input  1  empty the board
row_read  input  3  read address, row
col_read  input  3  read address, column
data_out  output  2  cell contents at (row_read, col_read)
board_full  output  1  see Optional Feature

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - all cells 00; state IDLE.
  - drop_done, drop_ok, check_start = 0; move_row, move_col = 0.
- Reset mid-drop aborts the drop: no done pulse.
- Cell encoding: 00 empty, 01 P1, 10 P2. The value 11 is never written.
- Read port:
  - data_out is combinational from the registered cells.
  - Out-of-range address (row >= NUM_ROWS or col >= NUM_COLS) returns 00.
  - A cell written at an edge is visible on data_out only after that edge.
- States: IDLE, SCAN, WRITE.
- IDLE:
  - A handshake is drop_valid & drop_ready.
  - On a handshake with drop_col < NUM_COLS and player in {01, 10}: latch col and player, set scan_row = 0, go to SCAN.
  - On a handshake with invalid col or player: stay in IDLE; next cycle drop_done=1, drop_ok=0, no check_start.
- SCAN, one row per cycle:
  - cell(scan_row, col) == 00: go to WRITE.
  - Occupied and scan_row == NUM_ROWS-1 (column full): drop_done=1, drop_ok=0, go to IDLE.
  - Otherwise: scan_row increments.
- WRITE:
  - cell(scan_row, col) <= player; move_row <= scan_row; move_col <= col.
  - drop_done, drop_ok, check_start = 1 for the next cycle; go to IDLE.
- Latency, measured from the accepting edge to the first cycle with drop_done high:
  - landing row r: r + 2 cycles (empty column: 2);
  - full column: NUM_ROWS cycles.
- drop_done, drop_ok and check_start are 0 on all other cycles.
- move_row/move_col hold their value until the next successful write.
- clear_board:
  - Any state: all cells 00 at the next edge; state returns to IDLE.
  - An in-flight drop is aborted with no done pulse.
  - clear_board has priority over a simultaneous drop_valid; drop_ready is 0 while clear_board is high.
- New requests are ignored while not in IDLE (drop_ready = 0).

Optional Feature:
- Macro BOARD_FULL_DETECT_EN.
- Defined:
  - a 6-bit piece counter increments on every WRITE and is zeroed on reset and on clear_board;
  - board_full = (count == NUM_ROWS*NUM_COLS);
  - while board_full is high, drops are rejected from IDLE like invalid requests (drop_done=1, drop_ok=0, one cycle after the handshake).
- Not defined: no counter; board_full is tied to 0.

Decomposition:
- Shared package board_pkg:
  - NUM_ROWS, NUM_COLS defaults;
  - cell codes CELL_EMPTY=2'b00, CELL_P1=2'b01, CELL_P2=2'b10;
  - drop FSM state encodings.
- One sub-module, board_cells:
  - owns the register array, synchronous clear and reset, and one write port (we, wrow, wcol, wdata);
  - has two combinational read ports: the external read port and the FSM scan port.
- The FSM stays in board_store.

Test Plan:
- Reset, then drop col 3 player 01 → drop_done two cycles after accept, drop_ok=1, check_start=1, move_row=0, move_col=3; data_out at (0,3) = 01.
- Six alternating drops into col 0, then a seventh → the seventh gives drop_ok=0 six cycles after accept, no check_start, and cells (0..5,0) are unchanged.
- Drop col 7, and separately player 11 → drop_done one cycle after accept, drop_ok=0, board unchanged.
- Three pieces in col 2, then a drop by player 10 → latency 5 cycles, move_row=3, data_out(3,2)=10; read (6,2) and (0,7) → 00.
- Assert clear_board during SCAN of a drop into col 4 with 2 pieces present → no drop_done, all reads 00, drop_ready=1 the cycle after clear_board drops.
- With BOARD_FULL_DETECT_EN, after 42 drops → board_full=1, the next drop is rejected one cycle after accept; clear_board → board_full=0.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants for the Connect-Four board store.
// Board geometry defaults, cell codes and drop FSM state encodings.
package board_pkg;

  localparam int NUM_ROWS = 6;
  localparam int NUM_COLS = 7;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  function automatic logic is_player(input logic [1:0] p);
    return (p == CELL_P1) || (p == CELL_P2);
  endfunction

endpackage

// File: rtl/board_cells.sv
// Board cell register array: one write port, two combinational read ports.
// Reset and clear both empty every cell at the next clock edge.
module board_cells
  import board_pkg::*;
#(
  parameter int NR = NUM_ROWS,
  parameter int NC = NUM_COLS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [2:0] i_wrow,
  input  logic [2:0] i_wcol,
  input  logic [1:0] i_wdata,
  input  logic [2:0] i_rrow,
  input  logic [2:0] i_rcol,
  output logic [1:0] o_rdata,
  input  logic [2:0] i_srow,
  input  logic [2:0] i_scol,
  output logic [1:0] o_sdata
);

  localparam logic [3:0] LR = 4'(NR);
  localparam logic [3:0] LC = 4'(NC);

  logic [1:0] r_cells [NR][NC];

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          r_cells[r][c] <= CELL_EMPTY;
    end else if (i_we) begin
      r_cells[i_wrow][i_wcol] <= i_wdata;
    end
  end

  // Addresses off the board read as empty
  always_comb begin
    o_rdata = CELL_EMPTY;
    if (({1'b0, i_rrow} < LR) && ({1'b0, i_rcol} < LC))
      o_rdata = r_cells[i_rrow][i_rcol];
  end

  always_comb begin
    o_sdata = CELL_EMPTY;
    if (({1'b0, i_srow} < LR) && ({1'b0, i_scol} < LC))
      o_sdata = r_cells[i_srow][i_scol];
  end

endmodule

// File: rtl/board_store.sv
// Connect-Four board owner with bottom-up drop FSM and read port.
// Define BOARD_FULL_DETECT_EN to count pieces and reject drops on a full board.
module board_store
  import board_pkg::*;
#(
  parameter int NUM_ROWS = board_pkg::NUM_ROWS,
  parameter int NUM_COLS = board_pkg::NUM_COLS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  input  logic [1:0] player,
  output logic       drop_ready,
  output logic       drop_done,
  output logic       drop_ok,
  output logic [2:0] move_row,
  output logic [2:0] move_col,
  output logic       check_start,
  input  logic       clear_board,
  input  logic [2:0] row_read,
  input  logic [2:0] col_read,
  output logic [1:0] data_out,
  output logic       board_full
);

  localparam logic [3:0] LC   = 4'(NUM_COLS);
  localparam logic [2:0] TOPR = 3'(NUM_ROWS - 1);

  logic [1:0] r_state;
  logic [2:0] r_col;
  logic [1:0] r_player;
  logic [2:0] r_row;
  logic       r_done;
  logic       r_ok;
  logic       r_chk;
  logic [2:0] r_mrow;
  logic [2:0] r_mcol;

  logic [1:0] w_sdata;
  logic       w_hs;
  logic       w_req_ok;
  logic       w_full;
  logic       w_we;

`ifdef BOARD_FULL_DETECT_EN
  logic [5:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_board)
      r_count <= 6'd0;
    else if (r_state == ST_WRITE)
      r_count <= r_count + 6'd1;
  end

  assign w_full = (r_count == 6'(NUM_ROWS * NUM_COLS));
`else
  assign w_full = 1'b0;
`endif

  assign board_full = w_full;
  assign drop_ready = (r_state == ST_IDLE) && !clear_board;
  assign w_hs       = drop_valid && drop_ready;
  assign w_req_ok   = ({1'b0, drop_col} < LC) && is_player(player)
                    && !w_full;
  assign w_we       = (r_state == ST_WRITE) && !clear_board;

  assign drop_done   = r_done;
  assign drop_ok     = r_ok;
  assign check_start = r_chk;
  assign move_row    = r_mrow;
  assign move_col    = r_mcol;

  board_cells #(
    .NR (NUM_ROWS),
    .NC (NUM_COLS)
  ) u_cells (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clear_board),
    .i_we    (w_we),
    .i_wrow  (r_row),
    .i_wcol  (r_col),
    .i_wdata (r_player),
    .i_rrow  (row_read),
    .i_rcol  (col_read),
    .o_rdata (data_out),
    .i_srow  (r_row),
    .i_scol  (r_col),
    .o_sdata (w_sdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_col    <= 3'd0;
      r_player <= CELL_EMPTY;
      r_row    <= 3'd0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_chk    <= 1'b0;
      r_mrow   <= 3'd0;
      r_mcol   <= 3'd0;
    end else begin
      r_done <= 1'b0;
      r_ok   <= 1'b0;
      r_chk  <= 1'b0;
      if (clear_board) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_hs) begin
              if (w_req_ok) begin
                r_col    <= drop_col;
                r_player <= player;
                r_row    <= 3'd0;
                r_state  <= ST_SCAN;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_SCAN: begin
            if (w_sdata == CELL_EMPTY) begin
              r_state <= ST_WRITE;
            end else if (r_row == TOPR) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_row <= r_row + 3'd1;
            end
          end
          ST_WRITE: begin
            r_mrow  <= r_row;
            r_mcol  <= r_col;
            r_done  <= 1'b1;
            r_ok    <= 1'b1;
            r_chk   <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
